// File: rtl/skill_pkg.sv
// rtl/skill_pkg.sv - shared types, constants and helpers for the skill scheduler
// Purpose : per-skill FSM state encoding, skill indices, default timings,
//           and the thermometer encoder used for the LED point bar.
// Ports   : none (package).
package skill_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACTIVE   = 2'd1,
      COOLDOWN = 2'd2
   } skill_state_e;

   localparam int NUM_SKILLS = 3;
   localparam int SK_BULLET  = 0;
   localparam int SK_FAST    = 1;
   localparam int SK_X       = 2;

   localparam int DEF_MAX_POINTS = 3;
   localparam int DEF_DUR_0      = 40;
   localparam int DEF_DUR_1      = 60;
   localparam int DEF_DUR_2      = 40;
   localparam int DEF_COOL       = 20;

   // MSB-first thermometer; the bar only has three LEDs, so 3+ points
   // light all of them.
   function automatic logic [2:0] therm(input logic [2:0] n);
      logic [2:0] bar;
      case (n)
         3'd0:    bar = 3'b000;
         3'd1:    bar = 3'b100;
         3'd2:    bar = 3'b110;
         default: bar = 3'b111;
      endcase
      return bar;
   endfunction

endpackage

// File: rtl/skill_timer.sv
// rtl/skill_timer.sv - per-skill FSM with duration and optional cooldown counter
// Purpose : IDLE -> ACTIVE -> (COOLDOWN) -> IDLE for one skill. Everything
//           freezes while enable is low. Cooldown exists only when
//           SKILL_COOLDOWN_EN is defined.
// Ports   : clk, rst      - game tick, synchronous active-high reset
//           enable        - play stage; low freezes state and counter
//           grant         - arbiter grant for this skill (only acted on in IDLE)
//           duration      - active ticks for this skill (>= 1)
//           cool          - cooldown ticks (>= 1), SKILL_COOLDOWN_EN builds only
//           idle, active  - registered state flags
module skill_timer
   import skill_pkg::*;
#(
   parameter int DUR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             grant,
   input  logic [DUR_W-1:0] duration,
`ifdef SKILL_COOLDOWN_EN
   input  logic [DUR_W-1:0] cool,
`endif
   output logic             idle,
   output logic             active
);

   skill_state_e     state_q;
   logic [DUR_W-1:0] cnt_q;
   logic             idle_q;
   logic             active_q;

   // The counter holds "ticks remaining minus one", so a load of N-1
   // yields exactly N cycles in the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idle_q   <= 1'b1;
         active_q <= 1'b0;
      end else if (enable) begin
         case (state_q)
            IDLE: begin
               if (grant) begin
                  state_q  <= ACTIVE;
                  cnt_q    <= duration - DUR_W'(1);
                  idle_q   <= 1'b0;
                  active_q <= 1'b1;
               end
            end
            ACTIVE: begin
               if (cnt_q == '0) begin
                  active_q <= 1'b0;
`ifdef SKILL_COOLDOWN_EN
                  state_q  <= COOLDOWN;
                  cnt_q    <= cool - DUR_W'(1);
`else
                  state_q  <= IDLE;
                  idle_q   <= 1'b1;
`endif
               end else begin
                  cnt_q <= cnt_q - DUR_W'(1);
               end
            end
            COOLDOWN: begin
               if (cnt_q == '0) begin
                  state_q <= IDLE;
                  idle_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - DUR_W'(1);
               end
            end
            default: begin
               state_q  <= IDLE;
               cnt_q    <= '0;
               idle_q   <= 1'b1;
               active_q <= 1'b0;
            end
         endcase
      end
   end

   assign idle   = idle_q;
   assign active = active_q;

endmodule

// File: rtl/skill_scheduler.sv
// rtl/skill_scheduler.sv - skill request arbiter, point pool and skill timers
// Purpose : grants at most one skill per tick (priority 2 > 1 > 0) against a
//           shared point pool, runs one skill_timer per skill and drives the
//           LED point bar. Optional cooldown: define SKILL_COOLDOWN_EN.
// Ports   : clk, rst      - game tick, synchronous active-high reset
//           enable        - play stage; low ignores requests and freezes timers
//           req[2:0]      - one-cycle skill requests
//           refill        - restore pool to MAX_POINTS (wins over everything)
//           point_add     - +1 point, saturating
//           skill_start   - registered one-cycle grant pulse per skill
//           skill_active  - skill in effect
//           skill_point   - current pool
//           point_bar     - MSB-first thermometer of skill_point
//           denied        - request seen with enable high but nothing granted
module skill_scheduler
   import skill_pkg::*;
#(
   parameter int MAX_POINTS = DEF_MAX_POINTS,
   parameter int DUR_W      = 8,
   parameter int DUR_0      = DEF_DUR_0,
   parameter int DUR_1      = DEF_DUR_1,
   parameter int DUR_2      = DEF_DUR_2,
   parameter int COOL       = DEF_COOL
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [2:0] req,
   input  logic       refill,
   input  logic       point_add,
   output logic [2:0] skill_start,
   output logic [2:0] skill_active,
   output logic [2:0] skill_point,
   output logic [2:0] point_bar,
   output logic       denied
);

   localparam logic [2:0] MAX_PT = 3'(MAX_POINTS);
   localparam logic [DUR_W-1:0] DURS [NUM_SKILLS] =
      '{DUR_W'(DUR_0), DUR_W'(DUR_1), DUR_W'(DUR_2)};

   logic [2:0] idle_w;
   logic [2:0] active_w;
   logic [2:0] eligible;
   logic [2:0] grant_d;
   logic       denied_d;
   logic [2:0] pool_d;

   logic [2:0] pool_q;
   logic [2:0] bar_q;
   logic [2:0] start_q;
   logic       denied_q;

   always_comb begin
      eligible = req & idle_w & {3{enable && (pool_q != 3'd0)}};

      grant_d = 3'b000;
      if (eligible[SK_X])           grant_d[SK_X]      = 1'b1;
      else if (eligible[SK_FAST])   grant_d[SK_FAST]   = 1'b1;
      else if (eligible[SK_BULLET]) grant_d[SK_BULLET] = 1'b1;

      denied_d = enable && (req != 3'b000) && (grant_d == 3'b000);

      // A grant and a point_add on the same edge cancel out.
      pool_d = pool_q;
      if (refill) begin
         pool_d = MAX_PT;
      end else if ((grant_d != 3'b000) && point_add) begin
         pool_d = pool_q;
      end else if (point_add) begin
         if (pool_q < MAX_PT) pool_d = pool_q + 3'd1;
      end else if (grant_d != 3'b000) begin
         pool_d = pool_q - 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pool_q   <= MAX_PT;
         bar_q    <= therm(MAX_PT);
         start_q  <= 3'b000;
         denied_q <= 1'b0;
      end else begin
         pool_q   <= pool_d;
         bar_q    <= therm(pool_d);
         start_q  <= grant_d;
         denied_q <= denied_d;
      end
   end

   for (genvar i = 0; i < NUM_SKILLS; i++) begin : g_timer
      skill_timer #(
         .DUR_W(DUR_W)
      ) u_timer (
         .clk      (clk),
         .rst      (rst),
         .enable   (enable),
         .grant    (grant_d[i]),
         .duration (DURS[i]),
`ifdef SKILL_COOLDOWN_EN
         .cool     (DUR_W'(COOL)),
`endif
         .idle     (idle_w[i]),
         .active   (active_w[i])
      );
   end

   assign skill_start  = start_q;
   assign skill_active = active_w;
   assign skill_point  = pool_q;
   assign point_bar    = bar_q;
   assign denied       = denied_q;

endmodule

// File: tb/tb_skill_scheduler.sv
// tb/tb_skill_scheduler.sv - directed self-checking bench for skill_scheduler
module tb_skill_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [2:0] req;
   logic       refill;
   logic       point_add;
   logic [2:0] skill_start;
   logic [2:0] skill_active;
   logic [2:0] skill_point;
   logic [2:0] point_bar;
   logic       denied;

   int tests_run    = 0;
   int tests_failed = 0;

   skill_scheduler dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .req          (req),
      .refill       (refill),
      .point_add    (point_add),
      .skill_start  (skill_start),
      .skill_active (skill_active),
      .skill_point  (skill_point),
      .point_bar    (point_bar),
      .denied       (denied)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b1; req = 3'b000; refill = 1'b0; point_add = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests_run++; if (skill_point !== 3'd3) begin tests_failed++; $display("FAIL reset_point: got %0d expected 3", skill_point); end
      tests_run++; if (point_bar !== 3'b111) begin tests_failed++; $display("FAIL reset_bar: got %b expected 111", point_bar); end
      tests_run++; if (skill_start !== 3'b000) begin tests_failed++; $display("FAIL reset_start: got %b expected 000", skill_start); end
      tests_run++; if (skill_active !== 3'b000) begin tests_failed++; $display("FAIL reset_active: got %b expected 000", skill_active); end
      tests_run++; if (denied !== 1'b0) begin tests_failed++; $display("FAIL reset_denied: got %b expected 0", denied); end
   endtask

   task automatic test_single_grant();
      int cnt;
      do_reset();
      req = 3'b001; tick(); req = 3'b000;
      tests_run++; if (skill_start !== 3'b001) begin tests_failed++; $display("FAIL single_start: got %b expected 001", skill_start); end
      tests_run++; if (skill_point !== 3'd2) begin tests_failed++; $display("FAIL single_point: got %0d expected 2", skill_point); end
      tests_run++; if (point_bar !== 3'b110) begin tests_failed++; $display("FAIL single_bar: got %b expected 110", point_bar); end
      tests_run++; if (denied !== 1'b0) begin tests_failed++; $display("FAIL single_denied: got %b expected 0", denied); end
      cnt = 0;
      for (int k = 0; k < 100; k++) begin
         if (!skill_active[0]) break;
         cnt++;
         tick();
         if (k == 0) begin
            tests_run++; if (skill_start !== 3'b000) begin tests_failed++; $display("FAIL single_start_pulse: got %b expected 000", skill_start); end
         end
      end
      tests_run++; if (cnt !== 40) begin tests_failed++; $display("FAIL single_active_len: got %0d expected 40", cnt); end
   endtask

   task automatic test_priority_drain();
      do_reset();
      req = 3'b111; tick();
      tests_run++; if (skill_start !== 3'b100) begin tests_failed++; $display("FAIL prio_first_start: got %b expected 100", skill_start); end
      tests_run++; if (skill_point !== 3'd2) begin tests_failed++; $display("FAIL prio_first_point: got %0d expected 2", skill_point); end
      tests_run++; if (denied !== 1'b0) begin tests_failed++; $display("FAIL prio_first_denied: got %b expected 0", denied); end
      tick();
      tests_run++; if (skill_start !== 3'b010) begin tests_failed++; $display("FAIL prio_second_start: got %b expected 010", skill_start); end
      tests_run++; if (skill_point !== 3'd1) begin tests_failed++; $display("FAIL prio_second_point: got %0d expected 1", skill_point); end
      req = 3'b001; tick(); req = 3'b000;
      tests_run++; if (skill_point !== 3'd0) begin tests_failed++; $display("FAIL drain_point: got %0d expected 0", skill_point); end
      tests_run++; if (point_bar !== 3'b000) begin tests_failed++; $display("FAIL drain_bar: got %b expected 000", point_bar); end
      for (int k = 0; k < 200; k++) begin
         if (!skill_active[2]) break;
         tick();
      end
      tests_run++; if (skill_active[2] !== 1'b0) begin tests_failed++; $display("FAIL drain_timeout: skill2 active got %b expected 0", skill_active[2]); end
`ifdef SKILL_COOLDOWN_EN
      repeat (25) tick();
`endif
      req = 3'b100; tick(); req = 3'b000;
      tests_run++; if (denied !== 1'b1) begin tests_failed++; $display("FAIL empty_denied: got %b expected 1", denied); end
      tests_run++; if (skill_start !== 3'b000) begin tests_failed++; $display("FAIL empty_start: got %b expected 000", skill_start); end
      tests_run++; if (skill_point !== 3'd0) begin tests_failed++; $display("FAIL empty_point: got %0d expected 0", skill_point); end
      tick();
      tests_run++; if (denied !== 1'b0) begin tests_failed++; $display("FAIL denied_pulse: got %b expected 0", denied); end
   endtask

   task automatic test_pause();
      int cnt;
      int hold_ok;
      do_reset();
      req = 3'b010; tick(); req = 3'b000;
      tests_run++; if (skill_active !== 3'b010) begin tests_failed++; $display("FAIL pause_grant: got %b expected 010", skill_active); end
      cnt = 0;
      hold_ok = 1;
      for (int k = 0; k < 200; k++) begin
         enable = !(k >= 20 && k < 30);
         req = (k == 25) ? 3'b001 : 3'b000;
         if (!skill_active[1]) break;
         if (enable) cnt++;
         tick();
         if (!enable && skill_active[1] !== 1'b1) hold_ok = 0;
         if (!enable && (denied !== 1'b0 || skill_start !== 3'b000)) hold_ok = 0;
      end
      enable = 1'b1;
      req = 3'b000;
      tests_run++; if (cnt !== 60) begin tests_failed++; $display("FAIL pause_active_len: got %0d expected 60", cnt); end
      tests_run++; if (hold_ok !== 1) begin tests_failed++; $display("FAIL pause_hold: got %0d expected 1", hold_ok); end
      req = 3'b010; tick(); req = 3'b000;
`ifdef SKILL_COOLDOWN_EN
      tests_run++; if (denied !== 1'b1) begin tests_failed++; $display("FAIL cooldown_denied: got %b expected 1", denied); end
      tests_run++; if (skill_point !== 3'd2) begin tests_failed++; $display("FAIL cooldown_point: got %0d expected 2", skill_point); end
`else
      tests_run++; if (skill_start !== 3'b010) begin tests_failed++; $display("FAIL regrant_start: got %b expected 010", skill_start); end
      tests_run++; if (skill_point !== 3'd1) begin tests_failed++; $display("FAIL regrant_point: got %0d expected 1", skill_point); end
`endif
   endtask

   task automatic test_pool();
      do_reset();
      req = 3'b100; tick();
      req = 3'b010; tick(); req = 3'b000;
      tests_run++; if (skill_point !== 3'd1) begin tests_failed++; $display("FAIL pool_setup: got %0d expected 1", skill_point); end
      refill = 1'b1; req = 3'b001; tick(); refill = 1'b0; req = 3'b000;
      tests_run++; if (skill_point !== 3'd3) begin tests_failed++; $display("FAIL refill_grant_point: got %0d expected 3", skill_point); end
      tests_run++; if (skill_start !== 3'b001) begin tests_failed++; $display("FAIL refill_grant_start: got %b expected 001", skill_start); end
      do_reset();
      point_add = 1'b1; tick(); point_add = 1'b0;
      tests_run++; if (skill_point !== 3'd3) begin tests_failed++; $display("FAIL add_saturate: got %0d expected 3", skill_point); end
      req = 3'b100; tick(); req = 3'b000;
      tests_run++; if (skill_point !== 3'd2) begin tests_failed++; $display("FAIL add_setup: got %0d expected 2", skill_point); end
      req = 3'b010; point_add = 1'b1; tick(); req = 3'b000; point_add = 1'b0;
      tests_run++; if (skill_point !== 3'd2) begin tests_failed++; $display("FAIL add_grant_point: got %0d expected 2", skill_point); end
      tests_run++; if (skill_start !== 3'b010) begin tests_failed++; $display("FAIL add_grant_start: got %b expected 010", skill_start); end
      req = 3'b001; tick(); req = 3'b000;
      point_add = 1'b1; tick(); point_add = 1'b0;
      tests_run++; if (skill_point !== 3'd2) begin tests_failed++; $display("FAIL add_alone_point: got %0d expected 2", skill_point); end
      tests_run++; if (point_bar !== 3'b110) begin tests_failed++; $display("FAIL add_alone_bar: got %b expected 110", point_bar); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 3'b001; tick(); req = 3'b000;
      repeat (5) tick();
      tests_run++; if (skill_active !== 3'b001) begin tests_failed++; $display("FAIL mid_pre_active: got %b expected 001", skill_active); end
      rst = 1'b1; tick(); rst = 1'b0;
      tests_run++; if (skill_active !== 3'b000) begin tests_failed++; $display("FAIL mid_active: got %b expected 000", skill_active); end
      tests_run++; if (skill_point !== 3'd3) begin tests_failed++; $display("FAIL mid_point: got %0d expected 3", skill_point); end
      req = 3'b001; tick(); req = 3'b000;
      tests_run++; if (skill_start !== 3'b001) begin tests_failed++; $display("FAIL mid_regrant_start: got %b expected 001", skill_start); end
      tests_run++; if (skill_active !== 3'b001) begin tests_failed++; $display("FAIL mid_regrant_active: got %b expected 001", skill_active); end
      tests_run++; if (skill_point !== 3'd2) begin tests_failed++; $display("FAIL mid_regrant_point: got %0d expected 2", skill_point); end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; req = 3'b000; refill = 1'b0; point_add = 1'b0;
      test_reset();
      test_single_grant();
      test_priority_drain();
      test_pause();
      test_pool();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
